// File: rtl/instr_encoder.sv
// instr_encoder: turns a one-hot MIPS instruction class plus operand fields into a
// 32-bit machine word, tagged with a word address, through a one-deep output register.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        cls,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [25:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  input  logic              clr_err
);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  logic              out_valid_q, out_valid_d, err_q, err_d;
  logic [31:0]       instr_q, instr_d, word;
  logic [ADDR_W-1:0] addr_q, addr_d, next_q, next_d;
  logic              legal, accept, load;
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;
  assign err       = err_q;
  always_comb begin
    legal  = (cls != 9'd0) && ((cls & (cls - 9'd1)) == 9'd0);
    accept = in_valid && in_ready;
    load   = accept && legal;
    word   = cls[0] ? {6'b000000, rs, rt, rd, 5'b00000, 6'b100001} :
             cls[1] ? {6'b000000, rs, rt, rd, 5'b00000, 6'b100011} :
             cls[2] ? {6'b001101, rs, rt, imm[15:0]} :
             cls[3] ? {6'b100011, rs, rt, imm[15:0]} :
             cls[4] ? {6'b101011, rs, rt, imm[15:0]} :
             cls[5] ? {6'b000100, rs, rt, imm[15:0]} :
             cls[6] ? {6'b001111, 5'b00000, rt, imm[15:0]} :
             cls[7] ? {6'b000011, imm} :
             cls[8] ? {6'b000000, rs, 15'd0, 6'b001000} : 32'd0;
    out_valid_d = load || (out_valid_q && !out_ready);
    instr_d     = load ? word : instr_q;
    addr_d      = load ? next_q : addr_q;
    next_d      = load ? next_q + 1'b1 : next_q;
    // an illegal accept on the same edge as a clear leaves err set
    err_d       = (accept && !legal) || (err_q && !clr_err);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      addr_q      <= BASE_A;
      next_q      <= BASE_A;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      next_q      <= next_d;
      err_q       <= err_d;
    end
  end
endmodule
